// File: rtl/apb_csr_bank_if.sv
// Conduit between the APB slave adapter and the CSR bank.
// The adapter drives requests (master) and the bank returns completions (slave).
interface apb_csr_bank_if #(
   parameter int A_WIDTH = 12,
   parameter int D_WIDTH = 32
);
   logic                 con_wr;
   logic                 con_rd;
   logic [A_WIDTH-1:0]   con_waddr;
   logic [A_WIDTH-1:0]   con_raddr;
   logic [D_WIDTH-1:0]   con_wdata;
   logic [D_WIDTH/8-1:0] con_wbyte_enable;
   logic [D_WIDTH/8-1:0] con_rbyte_enable;
   logic                 con_rd_ack;
   logic                 con_wr_ack;
   logic [D_WIDTH-1:0]   con_rdata;
   logic                 con_read_valid;
   logic                 con_slv_error;

   modport master (
      output con_wr, con_rd, con_waddr, con_raddr, con_wdata,
             con_wbyte_enable, con_rbyte_enable, con_rd_ack,
      input  con_wr_ack, con_rdata, con_read_valid, con_slv_error
   );

   modport slave (
      input  con_wr, con_rd, con_waddr, con_raddr, con_wdata,
             con_wbyte_enable, con_rbyte_enable, con_rd_ack,
      output con_wr_ack, con_rdata, con_read_valid, con_slv_error
   );
endinterface

// File: rtl/apb_csr_bank.sv
// CSR bank behind the APB conduit: ID, CTRL, STATUS, W1C IRQ_STATUS, IRQ_MASK, DATA[].
// Optional macro CSR_RO_WRITE_ERR_EN: writes to ID/STATUS return an error instead of an ack.
//
// state     | meaning
// ----------+--------------------------------------------------------------
// S_IDLE    | waiting for a request; latches address/data/strobes/kind/error
// S_WAIT    | counting down WAIT_CYCLES before responding
// S_RESP    | issues the single completion, commits write or captures read data
// S_RD_HOLD | read data held on con_rdata until con_rd_ack
module apb_csr_bank #(
   parameter int          D_WIDTH     = 32,
   parameter int          A_WIDTH     = 12,
   parameter int          NUM_DATA    = 8,
   parameter int          WAIT_CYCLES = 0,
   parameter logic [31:0] ID_VALUE    = 32'h0001_0100
) (
   input  logic                         pclk,
   input  logic                         presetn,
   apb_csr_bank_if.slave                con,
   output logic [D_WIDTH-1:0]           ctrl_o,
   input  logic [D_WIDTH-1:0]           status_i,
   input  logic [D_WIDTH-1:0]           irq_set_i,
   output logic                         irq_o,
   output logic [NUM_DATA*D_WIDTH-1:0]  data_o
);
   localparam int NB    = D_WIDTH / 8;
   localparam int IDX_W = A_WIDTH - 2;
`ifdef CSR_RO_WRITE_ERR_EN
   localparam bit RO_WR_ERR = 1'b1;
`else
   localparam bit RO_WR_ERR = 1'b0;
`endif

   typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP, S_RD_HOLD} state_t;

   state_t             state_q, state_d;
   logic [3:0]         cnt_q, cnt_d;
   logic [IDX_W-1:0]   idx_q, idx_d;
   logic [D_WIDTH-1:0] wdata_q, wdata_d;
   logic [NB-1:0]      wstrb_q, wstrb_d, rstrb_q, rstrb_d;
   logic               is_wr_q, is_wr_d, err_q, err_d;
   logic [D_WIDTH-1:0] ctrl_q, ctrl_d, mask_q, mask_d, irq_st_q, irq_st_d;
   logic [D_WIDTH-1:0] data_q [NUM_DATA];
   logic [D_WIDTH-1:0] data_d [NUM_DATA];
   logic               wr_ack_q, wr_ack_d, rvalid_q, rvalid_d, slv_err_q, slv_err_d;
   logic [D_WIDTH-1:0] rdata_q, rdata_d;
   logic               irq_q;
   logic [D_WIDTH-1:0] rd_val, irq_clr, wmask;
   logic [A_WIDTH-1:0] req_addr;

   function automatic logic [D_WIDTH-1:0] lanes(input logic [NB-1:0] s);
      logic [D_WIDTH-1:0] m;
      for (int b = 0; b < NB; b++) m[8*b +: 8] = {8{s[b]}};
      return m;
   endfunction

   function automatic logic addr_ok(input logic [A_WIDTH-1:0] a, input logic wr);
      logic [IDX_W-1:0] w;
      logic             ok;
      w  = a[A_WIDTH-1:2];
      ok = 1'b0;
      case (w)
         IDX_W'(0), IDX_W'(2):            ok = !(wr && RO_WR_ERR);
         IDX_W'(1), IDX_W'(3), IDX_W'(4): ok = 1'b1;
         default: begin
            for (int i = 0; i < NUM_DATA; i++)
               if (w == IDX_W'(8 + i)) ok = 1'b1;
         end
      endcase
      return ok && (a[1:0] == 2'b00);
   endfunction

   assign wmask    = lanes(wstrb_q);
   assign req_addr = con.con_wr ? con.con_waddr : con.con_raddr;

   always_comb begin
      rd_val = '0;
      case (idx_q)
         IDX_W'(0): rd_val = D_WIDTH'(ID_VALUE);
         IDX_W'(1): rd_val = ctrl_q;
         IDX_W'(2): rd_val = status_i;
         IDX_W'(3): rd_val = irq_st_q;
         IDX_W'(4): rd_val = mask_q;
         default: begin
            for (int i = 0; i < NUM_DATA; i++)
               if (idx_q == IDX_W'(8 + i)) rd_val = data_q[i];
         end
      endcase
   end

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      idx_d     = idx_q;
      wdata_d   = wdata_q;
      wstrb_d   = wstrb_q;
      rstrb_d   = rstrb_q;
      is_wr_d   = is_wr_q;
      err_d     = err_q;
      ctrl_d    = ctrl_q;
      mask_d    = mask_q;
      data_d    = data_q;
      irq_clr   = '0;
      wr_ack_d  = 1'b0;
      rvalid_d  = 1'b0;
      slv_err_d = 1'b0;
      rdata_d   = '0;

      case (state_q)
         S_IDLE: begin
            if (con.con_wr || con.con_rd) begin
               idx_d   = req_addr[A_WIDTH-1:2];
               wdata_d = con.con_wdata;
               wstrb_d = con.con_wbyte_enable;
               rstrb_d = con.con_rbyte_enable;
               is_wr_d = con.con_wr;
               err_d   = (con.con_wr && con.con_rd) || !addr_ok(req_addr, con.con_wr);
               if (WAIT_CYCLES > 0) begin
                  cnt_d   = 4'(WAIT_CYCLES - 1);
                  state_d = S_WAIT;
               end else begin
                  state_d = S_RESP;
               end
            end
         end
         S_WAIT: begin
            if (cnt_q == 4'd0) state_d = S_RESP;
            else               cnt_d   = cnt_q - 4'd1;
         end
         S_RESP: begin
            state_d = S_IDLE;
            if (err_q) begin
               slv_err_d = 1'b1;
            end else if (is_wr_q) begin
               wr_ack_d = 1'b1;
               case (idx_q)
                  IDX_W'(1): ctrl_d  = (ctrl_q & ~wmask) | (wdata_q & wmask);
                  IDX_W'(3): irq_clr = wdata_q & wmask;
                  IDX_W'(4): mask_d  = (mask_q & ~wmask) | (wdata_q & wmask);
                  default: begin
                     for (int i = 0; i < NUM_DATA; i++)
                        if (idx_q == IDX_W'(8 + i))
                           data_d[i] = (data_q[i] & ~wmask) | (wdata_q & wmask);
                  end
               endcase
            end else begin
               rvalid_d = 1'b1;
               rdata_d  = rd_val & lanes(rstrb_q);
               if (!con.con_rd_ack) state_d = S_RD_HOLD;
            end
         end
         S_RD_HOLD: begin
            if (con.con_rd_ack) state_d = S_IDLE;
            else                rdata_d = rdata_q;
         end
         default: state_d = S_IDLE;
      endcase

      // a set pulse on the same bit as a W1C clear wins
      irq_st_d = (irq_st_q & ~irq_clr) | irq_set_i;
   end

   always_ff @(posedge pclk or negedge presetn) begin
      if (!presetn) begin
         state_q   <= S_IDLE;
         cnt_q     <= '0;
         idx_q     <= '0;
         wdata_q   <= '0;
         wstrb_q   <= '0;
         rstrb_q   <= '0;
         is_wr_q   <= 1'b0;
         err_q     <= 1'b0;
         ctrl_q    <= '0;
         mask_q    <= '0;
         irq_st_q  <= '0;
         for (int i = 0; i < NUM_DATA; i++) data_q[i] <= '0;
         wr_ack_q  <= 1'b0;
         rvalid_q  <= 1'b0;
         slv_err_q <= 1'b0;
         rdata_q   <= '0;
         irq_q     <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         idx_q     <= idx_d;
         wdata_q   <= wdata_d;
         wstrb_q   <= wstrb_d;
         rstrb_q   <= rstrb_d;
         is_wr_q   <= is_wr_d;
         err_q     <= err_d;
         ctrl_q    <= ctrl_d;
         mask_q    <= mask_d;
         irq_st_q  <= irq_st_d;
         data_q    <= data_d;
         wr_ack_q  <= wr_ack_d;
         rvalid_q  <= rvalid_d;
         slv_err_q <= slv_err_d;
         rdata_q   <= rdata_d;
         irq_q     <= |(irq_st_q & mask_q);
      end
   end

   for (genvar g = 0; g < NUM_DATA; g++) begin : g_data
      assign data_o[g*D_WIDTH +: D_WIDTH] = data_q[g];
   end

   assign ctrl_o             = ctrl_q;
   assign irq_o              = irq_q;
   assign con.con_wr_ack     = wr_ack_q;
   assign con.con_read_valid = rvalid_q;
   assign con.con_slv_error  = slv_err_q;
   assign con.con_rdata      = rdata_q;
endmodule

// File: tb/tb_apb_csr_bank.sv
// Directed bench for apb_csr_bank: table of single transfers on a WAIT_CYCLES=0 instance,
// plus hand sequences for wait timing, read-hold handshake and reset abort on a WAIT_CYCLES=3 instance.
module tb_apb_csr_bank;
   localparam logic [2:0] K_ACK = 3'b100;
   localparam logic [2:0] K_VAL = 3'b010;
   localparam logic [2:0] K_ERR = 3'b001;
`ifdef CSR_RO_WRITE_ERR_EN
   localparam logic [2:0] K_RO = K_ERR;
`else
   localparam logic [2:0] K_RO = K_ACK;
`endif
   localparam logic [31:0] ID  = 32'h0001_0100;
   localparam logic [31:0] CT1 = 32'hA5A5_1234;
   localparam logic [31:0] CT2 = 32'hA5A5_BEEF;
   localparam logic [31:0] D2A = 32'hFF00_FF00;

   typedef struct {
      logic        wr;
      logic        rd;
      logic [11:0] addr;
      logic [31:0] wdata;
      logic [3:0]  be;
      logic [31:0] iset;
      logic [2:0]  ekind;
      logic [31:0] erdata;
      logic [31:0] ectrl;
      logic [31:0] ed2;
      logic        eirq;
   } vec_t;

   logic         pclk = 1'b0;
   logic         presetn;
   logic [31:0]  ctrl0, ctrl3, status0, status3, iset0, iset3;
   logic         irq0, irq3;
   logic [255:0] data0, data3;
   logic [2:0]   p0, p3;
   int           total = 0;
   int           bad   = 0;
   vec_t         vt[$];

   always #5 pclk = ~pclk;

   apb_csr_bank_if #(.A_WIDTH(12), .D_WIDTH(32)) if0 ();
   apb_csr_bank_if #(.A_WIDTH(12), .D_WIDTH(32)) if3 ();

   apb_csr_bank #(.WAIT_CYCLES(0)) dut0 (
      .pclk(pclk), .presetn(presetn), .con(if0), .ctrl_o(ctrl0), .status_i(status0),
      .irq_set_i(iset0), .irq_o(irq0), .data_o(data0)
   );
   apb_csr_bank #(.WAIT_CYCLES(3)) dut3 (
      .pclk(pclk), .presetn(presetn), .con(if3), .ctrl_o(ctrl3), .status_i(status3),
      .irq_set_i(iset3), .irq_o(irq3), .data_o(data3)
   );

   assign p0 = {if0.con_wr_ack, if0.con_read_valid, if0.con_slv_error};
   assign p3 = {if3.con_wr_ack, if3.con_read_valid, if3.con_slv_error};

   function automatic vec_t mk(input logic wr, input logic rd, input logic [11:0] a,
                               input logic [31:0] wd, input logic [3:0] be, input logic [31:0] is,
                               input logic [2:0] k, input logic [31:0] er, input logic [31:0] ec,
                               input logic [31:0] ed2, input logic ei);
      vec_t v;
      v.wr = wr; v.rd = rd; v.addr = a; v.wdata = wd; v.be = be; v.iset = is;
      v.ekind = k; v.erdata = er; v.ectrl = ec; v.ed2 = ed2; v.eirq = ei;
      return v;
   endfunction

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   // one transfer on the WAIT_CYCLES=3 instance; response expected on the 5th falling edge
   task automatic xfer3(input logic wr, input logic [11:0] addr, input logic [31:0] wd,
                        input logic [2:0] ekind, input logic [31:0] erd, input string nm,
                        output logic [31:0] ctrl_before);
      logic [2:0] early;
      @(negedge pclk);
      if3.con_wr = wr; if3.con_rd = !wr;
      if3.con_waddr = addr; if3.con_raddr = addr; if3.con_wdata = wd;
      if3.con_wbyte_enable = 4'hF; if3.con_rbyte_enable = 4'hF;
      early = 3'b000;
      ctrl_before = 32'h0;
      for (int k = 0; k < 4; k++) begin
         @(negedge pclk);
         if (k == 0) begin if3.con_wr = 1'b0; if3.con_rd = 1'b0; end
         early |= p3;
         if (k == 3) ctrl_before = ctrl3;
      end
      chk({nm, " early"}, {29'b0, early}, 32'h0);
      @(negedge pclk);
      chk({nm, " resp"}, {29'b0, p3}, {29'b0, ekind});
      if (!wr) chk({nm, " rdata"}, if3.con_rdata, erd);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1);
   end

   initial begin
      logic [31:0] cb, held;
      logic        stable;
      logic [2:0]  spur;

      presetn = 1'b0;
      status0 = 32'hCAFE_0008; status3 = 32'h5A5A_0003;
      iset0 = '0; iset3 = '0;
      if0.con_wr = 0; if0.con_rd = 0; if0.con_waddr = '0; if0.con_raddr = '0;
      if0.con_wdata = '0; if0.con_wbyte_enable = '0; if0.con_rbyte_enable = '0; if0.con_rd_ack = 1'b1;
      if3.con_wr = 0; if3.con_rd = 0; if3.con_waddr = '0; if3.con_raddr = '0;
      if3.con_wdata = '0; if3.con_wbyte_enable = '0; if3.con_rbyte_enable = '0; if3.con_rd_ack = 1'b0;

      vt.push_back(mk(1,0,12'h004,CT1,          4'hF,0,K_ACK,0,           CT1,0,           0));
      vt.push_back(mk(0,1,12'h000,0,            4'hF,0,K_VAL,ID,          CT1,0,           0));
      vt.push_back(mk(1,0,12'h028,32'hFFFF_FFFF,4'hF,0,K_ACK,0,           CT1,32'hFFFF_FFFF,0));
      vt.push_back(mk(1,0,12'h028,0,            4'h5,0,K_ACK,0,           CT1,D2A,         0));
      vt.push_back(mk(0,1,12'h028,0,            4'h6,0,K_VAL,32'h0000_FF00,CT1,D2A,        0));
      vt.push_back(mk(1,0,12'h010,1,            4'hF,3,K_ACK,0,           CT1,D2A,         1));
      vt.push_back(mk(0,1,12'h00C,0,            4'hF,0,K_VAL,3,           CT1,D2A,         1));
      vt.push_back(mk(1,0,12'h00C,1,            4'hF,1,K_ACK,0,           CT1,D2A,         1));
      vt.push_back(mk(1,0,12'h00C,1,            4'hF,0,K_ACK,0,           CT1,D2A,         0));
      vt.push_back(mk(0,1,12'h00C,0,            4'hF,0,K_VAL,2,           CT1,D2A,         0));
      vt.push_back(mk(0,1,12'h100,0,            4'hF,0,K_ERR,0,           CT1,D2A,         0));
      vt.push_back(mk(1,0,12'h006,32'hFFFF_FFFF,4'hF,0,K_ERR,0,           CT1,D2A,         0));
      vt.push_back(mk(1,1,12'h004,0,            4'hF,0,K_ERR,0,           CT1,D2A,         0));
      vt.push_back(mk(1,0,12'h008,32'h1234_5678,4'hF,0,K_RO, 0,           CT1,D2A,         0));
      vt.push_back(mk(0,1,12'h008,0,            4'hF,0,K_VAL,32'hCAFE_0008,CT1,D2A,        0));
      vt.push_back(mk(1,0,12'h000,32'hFFFF_FFFF,4'hF,0,K_RO, 0,           CT1,D2A,         0));
      vt.push_back(mk(0,1,12'h000,0,            4'hF,0,K_VAL,ID,          CT1,D2A,         0));
      vt.push_back(mk(1,0,12'h004,32'hDEAD_BEEF,4'h3,0,K_ACK,0,           CT2,D2A,         0));
      vt.push_back(mk(0,1,12'h040,0,            4'hF,0,K_ERR,0,           CT2,D2A,         0));
      vt.push_back(mk(0,1,12'h014,0,            4'hF,0,K_ERR,0,           CT2,D2A,         0));
      vt.push_back(mk(1,0,12'h03C,32'h1122_3344,4'hF,0,K_ACK,0,           CT2,D2A,         0));
      vt.push_back(mk(0,1,12'h03C,0,            4'hF,0,K_VAL,32'h1122_3344,CT2,D2A,        0));
      vt.push_back(mk(0,1,12'h004,0,            4'h9,0,K_VAL,32'hA500_00EF,CT2,D2A,        0));
      vt.push_back(mk(0,1,12'h00A,0,            4'hF,0,K_ERR,0,           CT2,D2A,         0));

      repeat (2) @(negedge pclk);
      chk("rst resp0",  {28'b0, irq0, p0}, 32'h0);
      chk("rst rdata0", if0.con_rdata, 32'h0);
      chk("rst ctrl0",  ctrl0, 32'h0);
      chk("rst data0",  {31'b0, |data0}, 32'h0);
      chk("rst out3",   {28'b0, irq3, p3} | if3.con_rdata | ctrl3 | {31'b0, |data3}, 32'h0);
      presetn = 1'b1;

      foreach (vt[i]) begin
         @(negedge pclk);
         if0.con_wr = vt[i].wr; if0.con_rd = vt[i].rd;
         if0.con_waddr = vt[i].addr; if0.con_raddr = vt[i].addr;
         if0.con_wdata = vt[i].wdata;
         if0.con_wbyte_enable = vt[i].be; if0.con_rbyte_enable = vt[i].be;
         @(negedge pclk);
         if0.con_wr = 1'b0; if0.con_rd = 1'b0;
         iset0 = vt[i].iset;
         chk($sformatf("v%0d early", i), {29'b0, p0}, 32'h0);
         @(negedge pclk);
         iset0 = '0;
         chk($sformatf("v%0d resp", i),  {29'b0, p0}, {29'b0, vt[i].ekind});
         chk($sformatf("v%0d rdata", i), if0.con_rdata, vt[i].erdata);
         chk($sformatf("v%0d ctrl", i),  ctrl0, vt[i].ectrl);
         chk($sformatf("v%0d data2", i), data0[95:64], vt[i].ed2);
         @(negedge pclk);
         chk($sformatf("v%0d late", i),  {29'b0, p0} | if0.con_rdata, 32'h0);
         chk($sformatf("v%0d irq", i),   {31'b0, irq0}, {31'b0, vt[i].eirq});
      end
      chk("data7", data0[255:224], 32'h1122_3344);

      // wait-state write: ctrl_o changes on the ack edge, not before
      xfer3(1'b1, 12'h004, 32'h0BAD_F00D, K_ACK, 32'h0, "w3 ctrl", cb);
      chk("w3 ctrl before", cb, 32'h0);
      chk("w3 ctrl after", ctrl3, 32'h0BAD_F00D);

      // read STATUS, then stall con_rd_ack and try to sneak a request in
      if3.con_rd_ack = 1'b0;
      xfer3(1'b0, 12'h008, 32'h0, K_VAL, 32'h5A5A_0003, "w3 status", cb);
      held = if3.con_rdata;
      stable = 1'b1;
      spur = 3'b000;
      for (int k = 1; k <= 5; k++) begin
         @(negedge pclk);
         if (k == 1) begin if3.con_rd = 1'b1; if3.con_raddr = 12'h000; end
         if (k == 2) if3.con_rd = 1'b0;
         stable &= (if3.con_rdata === held);
         spur |= p3;
      end
      chk("hold stable", {31'b0, stable}, 32'h1);
      chk("hold nopulse", {29'b0, spur}, 32'h0);
      if3.con_rd_ack = 1'b1;
      @(negedge pclk);
      if3.con_rd_ack = 1'b0;
      chk("hold exit rdata", if3.con_rdata, 32'h0);
      spur = 3'b000;
      repeat (5) begin
         @(negedge pclk);
         spur |= p3;
      end
      chk("ignored req", {29'b0, spur}, 32'h0);

      if3.con_rd_ack = 1'b1;
      xfer3(1'b0, 12'h000, 32'h0, K_VAL, ID, "w3 id", cb);

      // reset during WAIT of a CTRL write
      @(negedge pclk);
      if3.con_wr = 1'b1; if3.con_waddr = 12'h004; if3.con_wdata = 32'h1234_5678;
      if3.con_wbyte_enable = 4'hF;
      @(negedge pclk);
      if3.con_wr = 1'b0;
      @(negedge pclk);
      presetn = 1'b0;
      @(negedge pclk);
      presetn = 1'b1;
      spur = 3'b000;
      repeat (6) begin
         @(negedge pclk);
         spur |= p3;
      end
      chk("abort nopulse", {29'b0, spur}, 32'h0);
      chk("abort ctrl3", ctrl3, 32'h0);
      chk("abort ctrl0", ctrl0, 32'h0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/apb_csr_bank.md
# apb_csr_bank

- Register bank that sits directly downstream of the APB slave adapter's conduit.
- Decodes conduit write/read requests into a fixed CSR map: ID, control, status, W1C interrupt status, interrupt mask, and up to 8 data words.
- Returns one-cycle ack / read-valid / error pulses after a programmable number of wait cycles.
- Exports control, data and interrupt outputs to the core.

## Interface
- `D_WIDTH`, 32: data width; only 32 is supported.
- `A_WIDTH`, 12: byte address width.
- `NUM_DATA`, 8: number of DATA registers, 1..8.
- `WAIT_CYCLES`, 0: extra cycles between request and response, 0..15.
- `ID_VALUE`, 32'h0001_0100: constant returned by the ID register.
- `pclk` in 1: clock.
- `presetn` in 1: asynchronous active-low reset.
- `con_wr` in 1: write request pulse.
- `con_rd` in 1: read request pulse.
- `con_waddr` in A_WIDTH: write byte address.
- `con_raddr` in A_WIDTH: read byte address.
- `con_wdata` in D_WIDTH: write data.
- `con_wbyte_enable` in D_WIDTH/8: write lane strobes.
- `con_rbyte_enable` in D_WIDTH/8: read lane enables; disabled lanes return 0.
- `con_rd_ack` in 1: adapter has consumed read data.
- `con_wr_ack` out 1: write completion pulse.
- `con_rdata` out D_WIDTH: read data, valid with `con_read_valid`.
- `con_read_valid` out 1: read completion pulse.
- `con_slv_error` out 1: error completion pulse; replaces the ack/valid pulse.
- `ctrl_o` out D_WIDTH: CTRL register.
- `status_i` in D_WIDTH: live status, read through STATUS.
- `irq_set_i` in D_WIDTH: per-bit set pulses for IRQ_STATUS.
- `irq_o` out 1: `|(IRQ_STATUS & IRQ_MASK)`, registered.
- `data_o` out NUM_DATA*D_WIDTH: DATA registers, DATA[0] in the LSBs.

## Operation
- Map, byte offsets; word index is `addr[A_WIDTH-1:2]`:
  - 0x000 ID: RO.
  - 0x004 CTRL: RW.
  - 0x008 STATUS: RO.
  - 0x00C IRQ_STATUS: W1C.
  - 0x010 IRQ_MASK: RW.
  - 0x020 + 4*i DATA[i]: RW, i < NUM_DATA.
- Any other address → error response; no register change.
- Misaligned request (`addr[1:0] != 0`) → error response.
- RW writes update only lanes with the strobe set; lanes with the strobe clear keep their value.
- IRQ_STATUS: a write clears bits where data=1 on strobed lanes. `irq_set_i` sets bits every cycle. On the same bit in the same cycle, set wins.
- `con_wr` and `con_rd` high in the same IDLE cycle → error response; no register change.
- FSM states:
  - IDLE: on a request, latch address/data/strobes/kind/error flag; go to WAIT if WAIT_CYCLES>0, else RESP.
  - WAIT: count down WAIT_CYCLES; go to RESP when the count reaches 0.
  - RESP: pulse exactly one of `con_wr_ack`, `con_read_valid` or `con_slv_error`; commit the write or capture read data. Next state:
    - write or error → IDLE;
    - read with `con_rd_ack` high in the same cycle → IDLE;
    - read otherwise → RD_HOLD.
  - RD_HOLD: hold `con_rdata`; go to IDLE on `con_rd_ack`.
- Requests arriving outside IDLE are ignored.

## Timing
- Request sampled at edge E (W = WAIT_CYCLES).
- Response pulse is high for exactly one cycle, between edges E+W+1 and E+W+2.
- Write data is visible on `ctrl_o` / `data_o` from edge E+W+1, the same edge the ack rises.
- Read data is sampled at edge E+W+1. STATUS reflects `status_i` at edge E+W.
- `con_rdata` is held from the `con_read_valid` cycle until leaving RD_HOLD, and is 0 otherwise.
- `irq_o` follows a register change with 1 cycle of delay.
- Back-to-back throughput: one transfer per W+2 cycles minimum.
- Reset values:
  - All outputs 0.
  - CTRL, IRQ_STATUS, IRQ_MASK and all DATA registers 0.
  - FSM in IDLE; wait counter 0.
- Reset asserted mid-transfer: transfer aborted, no response pulse, pending write discarded.

## Configuration
- Macro `CSR_RO_WRITE_ERR_EN`.
- Defined: a write to ID or STATUS produces a `con_slv_error` pulse in RESP instead of `con_wr_ack`.
- Undefined: a write to ID or STATUS is ignored and acked normally with `con_wr_ack`.
- In both cases, reads of those registers behave identically.

## Test plan
- Reset, WAIT_CYCLES=0:
  - Write CTRL=0xA5A5_1234, strobes 0xF → `con_wr_ack` one cycle after the request; `ctrl_o`=0xA5A5_1234.
  - Read 0x000 → `con_read_valid` with rdata=0x0001_0100.
- Write DATA[2]=0xFFFF_FFFF, strobes 0xF, then 0x0000_0000 with strobes 0x5 → `data_o[95:64]`=0xFF00_FF00.
- IRQ path:
  - Set IRQ_MASK=0x1; pulse `irq_set_i`=0x3 → `irq_o`=1 and IRQ_STATUS reads 0x3.
  - Write 0x1 to 0x00C while `irq_set_i`=0x1 → bit stays set.
  - Write 0x1 to 0x00C with `irq_set_i`=0 → IRQ_STATUS=0x2, `irq_o`=0.
- Errors:
  - Read 0x100 → `con_slv_error` pulse, no `con_read_valid`.
  - Write 0x006 → error pulse, CTRL unchanged.
  - `con_wr` and `con_rd` together → error pulse.
- Timing and handshake, WAIT_CYCLES=3:
  - Read STATUS → response 4 cycles after the request.
  - Hold `con_rd_ack` low 5 cycles → `con_rdata` stable, a new `con_rd` is ignored, FSM returns to IDLE after `con_rd_ack`.
- Assert `presetn` in WAIT of a CTRL write → no ack, `ctrl_o`=0. With `CSR_RO_WRITE_ERR_EN`, a write to 0x008 → `con_slv_error`.
